iic_bus_monitor: RTL
====================

// Module: iic_bus_monitor
// PURPOSE
//  Passive IIC bus decoder directly downstream of the per-line edge detectors on SCL and SDA.
//  Consumes each line's level and its 1-cycle any-edge trigger.
//  Decodes START/STOP, shifts data bits MSB-first on SCL rising edges and reports each byte with its ACK bit.
//  Feeds the EEPROM IIC controller's checker and debug logic; never drives the bus.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  clk cycles without any SCL edge while busy before a timeout is declared
//  CNT_W           16     width of the timeout counter; TIMEOUT_CYCLES must be < 2**CNT_W
// PORTS
//  clk         in   1  system clock, all logic on posedge
//  rst_n       in   1  asynchronous, active-low reset
//  scl         in   1  synchronised SCL level (same signal fed to its edge detector)
//  sda         in   1  synchronised SDA level
//  scl_trig    in   1  SCL any-edge pulse, coincident with the new scl level
//  sda_trig    in   1  SDA any-edge pulse, coincident with the new sda level
//  start_pulse out  1  1-cycle pulse: START or repeated START decoded
//  stop_pulse  out  1  1-cycle pulse: STOP decoded
//  bus_busy    out  1  high from START until STOP, frame error or timeout
//  byte_valid  out  1  1-cycle pulse: byte_data/byte_ack/byte_first valid
//  byte_data   out  8  last complete byte, MSB first on the wire; held until next byte_valid
//  byte_ack    out  1  1 = ACK (SDA low on 9th SCL rise), 0 = NACK
//  byte_first  out  1  byte is the first after a (repeated) START, i.e. the address byte
//  frame_err   out  1  1-cycle pulse: START/STOP while bit_cnt != 0
//  timeout     out  1  1-cycle pulse: bus-stuck timeout (see CONFIGURATION)
// BEHAVIOUR
//  Edge decode, in the same cycle as the trigger:
//    scl_rise = scl_trig & scl
//    sda_fall = sda_trig & ~sda
//    sda_rise = sda_trig & sda
//  START = sda_fall & scl & ~scl_trig.  STOP = sda_rise & scl & ~scl_trig.
//  Simultaneous scl_trig & sda_trig: the SDA event is ignored as START/STOP; the SCL edge is processed
//  using the current sda level.
//  All outputs registered: every pulse asserts exactly 1 cycle after the triggering input cycle.
//  Reset: all outputs 0, byte_data 8'h00, state IDLE, bit_cnt 0, shreg 0, first_flag 0, timeout counter 0.
//  States:
//    IDLE: SCL edges and STOP ignored. START -> BUSY, bit_cnt=0, first_flag=1, start_pulse.
//    BUSY, on scl_rise:
//      bit_cnt 0..7: shreg <= {shreg[6:0], sda}; bit_cnt++.
//      bit_cnt 8 (ACK slot): byte_data <= shreg, byte_ack <= ~sda, byte_first <= first_flag, byte_valid;
//        then bit_cnt=0, first_flag=0.
//    BUSY, on START (repeated): start_pulse; bit_cnt=0, first_flag=1; frame_err too if bit_cnt != 0;
//      stays BUSY; partial byte discarded, no byte_valid.
//    BUSY, on STOP: stop_pulse and -> IDLE. frame_err too if bit_cnt != 0; partial byte discarded.
//  bus_busy = (state == BUSY), registered.
//  bit_cnt is 4 bits and never exceeds 8; wrap from 8 to 0 happens only at the ACK slot.
//  Reset asserted mid-frame: immediate return to IDLE. The bus is treated as free until the next START.
// CONFIGURATION
//  IIC_MON_TIMEOUT_EN defined:
//    Counter clears on any scl_trig, on START, and while IDLE; otherwise increments in BUSY.
//    On reaching TIMEOUT_CYCLES-1: timeout pulse, frame_err if bit_cnt != 0, -> IDLE, counter cleared.
//    Timeout has priority over an SCL/SDA event in the same cycle.
//  IIC_MON_TIMEOUT_EN undefined: no counter logic; timeout tied to 0; BUSY held indefinitely.
// TESTING
//  1. START, 0xA0 bits, ACK (SDA=0), STOP -> start_pulse;
//     byte_valid with data=8'hA0, ack=1, first=1; stop_pulse; bus_busy 1 then 0.
//  2. START, 0xA0+ACK, 0x05+ACK, rSTART, 0xA1+ACK, 0x5A+NACK, STOP -> 4 byte_valid:
//     A0/1/1, 05/1/0, A1/1/1, 5A/0/0; start_pulse x2.
//  3. START, 3 data bits, STOP -> frame_err and stop_pulse in the same cycle; no byte_valid; bus_busy=0.
//  4. scl_trig & sda_trig same cycle with scl=1, sda=0 while BUSY -> bit shifted in as 0;
//     no start_pulse.
//  5. SCL toggling and STOP while IDLE -> no outputs.
//     rst_n low mid-byte -> all outputs 0 immediately; next full byte decodes correctly.
//  6. IIC_MON_TIMEOUT_EN, TIMEOUT_CYCLES=100: START, 2 bits, SCL stalled -> timeout + frame_err on
//     the 100th idle cycle, bus_busy=0. Without the macro, timeout stays 0 and bus_busy stays 1.

Source files
------------

// File: rtl/iic_bus_monitor.sv
// Passive IIC bus decoder: START/STOP detection, MSB-first byte capture with ACK, framing errors.
// Optional bus-stuck timeout is built when IIC_MON_TIMEOUT_EN is defined; otherwise timeout stays 0.
module iic_bus_monitor #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl,
    input  logic       sda,
    input  logic       scl_trig,
    input  logic       sda_trig,
    output logic       start_pulse,
    output logic       stop_pulse,
    output logic       bus_busy,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       byte_ack,
    output logic       byte_first,
    output logic       frame_err,
    output logic       timeout
);

    localparam int unsigned BIT_CNT_W = 4;
    localparam int unsigned BYTE_W    = 8;
    localparam logic [BIT_CNT_W-1:0] ACK_SLOT = BIT_CNT_W'(8);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [BYTE_W-1:0]      shreg;
    logic                   first_flag;

    logic scl_rise_c;
    logic sda_fall_c;
    logic sda_rise_c;
    logic start_c;
    logic stop_c;
    logic partial_c;
    logic timeout_hit_c;

    // An SDA edge coincident with an SCL edge is never a START/STOP.
    assign scl_rise_c = scl_trig & scl;
    assign sda_fall_c = sda_trig & ~sda;
    assign sda_rise_c = sda_trig & sda;
    assign start_c    = sda_fall_c & scl & ~scl_trig;
    assign stop_c     = sda_rise_c & scl & ~scl_trig;
    assign partial_c  = (bit_cnt != '0);

`ifdef IIC_MON_TIMEOUT_EN
    logic [CNT_W-1:0] to_cnt;

    assign timeout_hit_c = (state == BUSY) && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counts busy cycles since the last SCL activity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if ((state == IDLE) || scl_trig || start_c || timeout_hit_c) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg    = ^{TIMEOUT_CYCLES, CNT_W};
    assign timeout_hit_c = 1'b0;
`endif

    // Frame state, bit shifter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            first_flag  <= 1'b0;
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            bus_busy    <= 1'b0;
            byte_valid  <= 1'b0;
            byte_data   <= 8'h00;
            byte_ack    <= 1'b0;
            byte_first  <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            stop_pulse  <= 1'b0;
            byte_valid  <= 1'b0;
            frame_err   <= 1'b0;
            timeout     <= 1'b0;

            case (state)
                IDLE: begin
                    if (start_c) begin
                        state       <= BUSY;
                        bus_busy    <= 1'b1;
                        bit_cnt     <= '0;
                        first_flag  <= 1'b1;
                        start_pulse <= 1'b1;
                    end
                end
                BUSY: begin
                    if (timeout_hit_c) begin
                        timeout   <= 1'b1;
                        frame_err <= partial_c;
                        state     <= IDLE;
                        bus_busy  <= 1'b0;
                        bit_cnt   <= '0;
                    end else if (start_c) begin
                        start_pulse <= 1'b1;
                        frame_err   <= partial_c;
                        bit_cnt     <= '0;
                        first_flag  <= 1'b1;
                    end else if (stop_c) begin
                        stop_pulse <= 1'b1;
                        frame_err  <= partial_c;
                        state      <= IDLE;
                        bus_busy   <= 1'b0;
                        bit_cnt    <= '0;
                    end else if (scl_rise_c) begin
                        if (bit_cnt == ACK_SLOT) begin
                            byte_data  <= shreg;
                            byte_ack   <= ~sda;
                            byte_first <= first_flag;
                            byte_valid <= 1'b1;
                            bit_cnt    <= '0;
                            first_flag <= 1'b0;
                        end else begin
                            shreg   <= {shreg[BYTE_W-2:0], sda};
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule
